// File: rtl/regfile_arb_pkg.sv
// Shared constants and the buffered multicycle-result type for the
// register-file write arbiter.
package regfile_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } md_entry_t;

endpackage

// File: rtl/regfile_arb_fifo.sv
// Multicycle result buffer: entry storage, pointers, occupancy and the parallel
// destination compare that kills buffered writes overtaken by a WB write.
// With WB_ARB_STATS_EN defined it also reports how many entries were killed.
module regfile_arb_fifo
    import regfile_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushDest,
    input  logic [DATA_W-1:0] pushData,
    input  logic              headGrant,
    input  logic              killEn,
    input  logic [ADDR_W-1:0] killDest,
    output md_entry_t         head,
    output logic [CNT_W-1:0]  count,
    output logic              popped
`ifdef WB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  killCount
`endif
);

    logic [DEPTH-1:0]  validQ;
    logic [ADDR_W-1:0] destQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [DEPTH-1:0]  killHit;

    // NOTE: combinational blocks use blocking '=', clocked blocks only '<='.
    always_comb begin
        killHit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            killHit[i] = killEn && validQ[i] && (destQ[i] == killDest);
        end
    end

    assign head   = '{valid: validQ[rdPtr], dest: destQ[rdPtr], data: dataQ[rdPtr]};
    // A killed head leaves silently; a live head leaves only when it wins the port.
    assign popped = (count != '0) && (!validQ[rdPtr] || headGrant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ <= '0;
            rdPtr  <= '0;
            wrPtr  <= '0;
            count  <= '0;
        end else begin
            validQ <= validQ & ~killHit;
            if (popped) begin
                validQ[rdPtr] <= 1'b0;
                rdPtr         <= rdPtr + 1'b1;
            end
            if (push) begin
                validQ[wrPtr] <= 1'b1;
                wrPtr         <= wrPtr + 1'b1;
            end
            case ({push, popped})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; the valid bits alone define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            destQ[wrPtr] <= pushDest;
            dataQ[wrPtr] <= pushData;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_comb begin
        killCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            killCount = killCount + CNT_W'(killHit[i]);
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the WB stage (priority) and a
// buffered multicycle unit, with a starvation stall. Define WB_ARB_STATS_EN for
// the stat_stalls / stat_kills counters.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wb_read_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_dest,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_pipe
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]       stat_stalls,
    output logic [15:0]       stat_kills
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    md_entry_t         head;
    logic [CNT_W-1:0]  fifoCount;
    logic              popped;
    logic              wbActive;
    logic              headGrant;
    logic              sameDestDrop;
    logic              push;
    logic              lostCycle;
    logic              stallTrigger;
    logic [WAIT_W-1:0] waitCnt;
`ifdef WB_ARB_STATS_EN
    logic [CNT_W-1:0]  killCount;
`endif

    // While stalled the pipeline holds WB, so its write simply replays next cycle.
    assign wbActive     = wb_reg_write && (wb_dest != ZERO_REG) && !stall_pipe;
    assign headGrant    = !wbActive && head.valid;
    assign md_ready     = rst_n && (fifoCount != CNT_W'(FIFO_DEPTH));
    assign sameDestDrop = wbActive && (md_dest == wb_dest);
    assign push         = md_valid && md_ready && (md_dest != ZERO_REG) && !sameDestDrop;
    assign lostCycle    = wbActive && head.valid;
    assign stallTrigger = lostCycle && (waitCnt == WAIT_W'(MAX_WAIT - 1));

    regfile_arb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pushDest (md_dest),
        .pushData (md_data),
        .headGrant(headGrant),
        .killEn   (wbActive),
        .killDest (wb_dest),
        .head     (head),
        .count    (fifoCount),
        .popped   (popped)
`ifdef WB_ARB_STATS_EN
        ,
        .killCount(killCount)
`endif
    );

    // NOTE: every output gets a default first so no latch can be inferred.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wbActive) begin
            rf_we    = 1'b1;
            rf_waddr = wb_dest;
            rf_wdata = wb_mem_to_reg ? wb_read_data : wb_alu_result;
        end else if (head.valid) begin
            rf_we    = 1'b1;
            rf_waddr = head.dest;
            rf_wdata = head.data;
        end
        if (!rst_n) begin
            rf_we = 1'b0;
        end
    end

    // Counting stops one short of MAX_WAIT: the stall itself is the MAX_WAIT-th step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt    <= '0;
            stall_pipe <= 1'b0;
        end else begin
            stall_pipe <= stallTrigger;
            if (popped || (fifoCount == '0) || stallTrigger) begin
                waitCnt <= '0;
            end else if (lostCycle) begin
                waitCnt <= waitCnt + 1'b1;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [CNT_W:0] killInc;
    logic [16:0]    stallSum;
    logic [16:0]    killSum;

    assign killInc  = {1'b0, killCount} + {{CNT_W{1'b0}}, (md_valid && md_ready && sameDestDrop)};
    assign stallSum = {1'b0, stat_stalls} + 17'(stall_pipe);
    assign killSum  = {1'b0, stat_kills} + 17'(killInc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stalls <= '0;
            stat_kills  <= '0;
        end else begin
            stat_stalls <= stallSum[16] ? 16'hFFFF : stallSum[15:0];
            stat_kills  <= killSum[16]  ? 16'hFFFF : killSum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] wb_read_data = '0;
    logic [DATA_W-1:0] wb_alu_result = '0;
    logic [ADDR_W-1:0] wb_dest = '0;
    logic              wb_reg_write = 1'b0;
    logic              wb_mem_to_reg = 1'b0;
    logic              md_valid = 1'b0;
    logic [ADDR_W-1:0] md_dest = '0;
    logic [DATA_W-1:0] md_data = '0;
    logic              md_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_pipe;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_read_data (wb_read_data),
        .wb_alu_result(wb_alu_result),
        .wb_dest      (wb_dest),
        .wb_reg_write (wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg),
        .md_valid     (md_valid),
        .md_dest      (md_dest),
        .md_data      (md_data),
        .md_ready     (md_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_pipe   (stall_pipe)
    );

    // Reference model: buffered results in arrival order, killed ones kept as placeholders.
    typedef struct {
        bit          valid;
        int          dest;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          waitLost;
    bit          stallExp;
    bit          mdAccepted;
    logic [31:0] modelRf[32];
    logic [31:0] dutRf[32];

    bit          expWe;
    int          expAddr;
    logic [31:0] expData;
    bit          wbWins;
    bit          headValid;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic evalModel();
        wbWins    = wb_reg_write && (wb_dest != 0) && !stallExp;
        headValid = (q.size() > 0) && q[0].valid;
        expWe     = 1'b0;
        expAddr   = 0;
        expData   = '0;
        if (wbWins) begin
            expWe   = 1'b1;
            expAddr = int'(wb_dest);
            expData = wb_mem_to_reg ? wb_read_data : wb_alu_result;
        end else if (headValid) begin
            expWe   = 1'b1;
            expAddr = q[0].dest;
            expData = q[0].data;
        end
    endtask

    task automatic compareOutputs();
        evalModel();
        check("rf_we", rf_we, expWe);
        if (expWe) begin
            check("rf_waddr", rf_waddr, expAddr);
            check("rf_wdata", rf_wdata, expData);
        end
        check("md_ready", md_ready, q.size() < DEPTH);
        check("stall_pipe", stall_pipe, stallExp);
    endtask

    task automatic advanceModel();
        bit accept;
        bit wasEmpty;
        bit lost;
        bit popped;
        bit nextStall;
        evalModel();
        if (expWe) modelRf[expAddr] = expData;
        if (rf_we) dutRf[rf_waddr] = rf_wdata;
        accept   = md_valid && (q.size() < DEPTH);
        wasEmpty = (q.size() == 0);
        lost     = wbWins && headValid;
        popped   = !wasEmpty && (!q[0].valid || !wbWins);
        if (popped) void'(q.pop_front());
        if (wbWins) begin
            foreach (q[i]) if (q[i].dest == int'(wb_dest)) q[i].valid = 1'b0;
        end
        if (accept && md_dest != 0 && !(wbWins && md_dest == wb_dest))
            q.push_back('{valid: 1'b1, dest: int'(md_dest), data: md_data});
        nextStall = 1'b0;
        if (lost) begin
            waitLost++;
            if (waitLost == MAXW) begin
                nextStall = 1'b1;
                waitLost  = 0;
            end
        end else if (popped || wasEmpty) begin
            waitLost = 0;
        end
        mdAccepted = accept;
        @(posedge clk);
        stallExp = nextStall;
    endtask

    // Inputs are driven 1ns after a rising edge; outputs are sampled 2ns later.
    task automatic cycle();
        #1;
        compareOutputs();
        advanceModel();
        #1;
    endtask

    task automatic setWb(input bit we, input int dest, input bit m2r,
                         input logic [31:0] rd, input logic [31:0] alu);
        wb_reg_write  = we;
        wb_dest       = ADDR_W'(dest);
        wb_mem_to_reg = m2r;
        wb_read_data  = rd;
        wb_alu_result = alu;
    endtask

    task automatic setMd(input bit v, input int dest, input logic [31:0] d);
        md_valid = v;
        md_dest  = ADDR_W'(dest);
        md_data  = d;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_stall", stall_pipe, 1'b0);
        setWb(0, 0, 0, '0, '0);
        setMd(0, 0, '0);
        q.delete();
        waitLost   = 0;
        stallExp   = 1'b0;
        mdAccepted = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        int busy;
        for (int r = 0; r < 32; r++) begin
            modelRf[r] = '0;
            dutRf[r]   = '0;
        end
        waitLost   = 0;
        stallExp   = 1'b0;
        mdAccepted = 1'b0;
        @(posedge clk);
        doReset();

        // WB only, then the register-0 suppression.
        setWb(1, 8, 1, 32'hCAFE0001, 32'h1234);
        #1;
        check("wb_we", rf_we, 1'b1);
        check("wb_waddr", rf_waddr, 8);
        check("wb_wdata", rf_wdata, 32'hCAFE0001);
        cycle();
        setWb(1, 0, 1, 32'hCAFE0002, 32'h1234);
        #1 check("wb_r0_we", rf_we, 1'b0);
        cycle();

        // Multicycle result into an idle port.
        setWb(0, 0, 0, '0, '0);
        setMd(1, 3, 32'h55);
        cycle();
        setMd(0, 0, '0);
        #1;
        check("md_we", rf_we, 1'b1);
        check("md_waddr", rf_waddr, 3);
        check("md_wdata", rf_wdata, 32'h55);
        cycle();
        #1;
        check("md_empty_we", rf_we, 1'b0);
        check("md_empty_ready", md_ready, 1'b1);
        cycle();

        // Full buffer holds off a third result until the starvation stall drains one.
        doReset();
        setWb(1, 20, 0, '0, 32'hA0);
        setMd(1, 4, 32'h44);
        cycle();
        setMd(1, 5, 32'h45);
        cycle();
        setMd(1, 6, 32'h46);
        #1 check("full_ready", md_ready, 1'b0);
        waited = 0;
        mdAccepted = 1'b0;
        while (!mdAccepted && waited < 20) begin
            cycle();
            waited++;
        end
        check("full_accepted", mdAccepted, 1'b1);
        setMd(0, 0, '0);
        setWb(0, 0, 0, '0, '0);
        repeat (4) cycle();

        // Starvation: four lost cycles, one stall cycle for the head, then WB lands.
        doReset();
        setWb(1, 10, 0, '0, 32'hB0B0);
        setMd(1, 3, 32'h77);
        cycle();
        setMd(0, 0, '0);
        for (int k = 0; k < MAXW; k++) begin
            #1;
            check("starve_nostall", stall_pipe, 1'b0);
            check("starve_wb_addr", rf_waddr, 10);
            cycle();
        end
        #1;
        check("starve_stall", stall_pipe, 1'b1);
        check("starve_head_we", rf_we, 1'b1);
        check("starve_head_addr", rf_waddr, 3);
        check("starve_head_data", rf_wdata, 32'h77);
        cycle();
        #1;
        check("starve_after_stall", stall_pipe, 1'b0);
        check("starve_wb_lands_addr", rf_waddr, 10);
        check("starve_wb_lands_data", rf_wdata, 32'hB0B0);
        cycle();
        setWb(0, 0, 0, '0, '0);
        repeat (2) cycle();

        // WAW: a WB write to r9 kills the buffered r9 result and drops a same-cycle one.
        doReset();
        setWb(1, 20, 0, '0, 32'hC0);
        setMd(1, 9, 32'h1);
        cycle();
        setWb(1, 9, 0, '0, 32'h2);
        setMd(1, 9, 32'h3);
        #1;
        check("waw_wb_addr", rf_waddr, 9);
        check("waw_wb_data", rf_wdata, 32'h2);
        cycle();
        setWb(0, 0, 0, '0, '0);
        setMd(0, 0, '0);
        #1 check("waw_killed_we", rf_we, 1'b0);
        cycle();
        #1;
        check("waw_dropped_we", rf_we, 1'b0);
        check("waw_ready", md_ready, 1'b1);
        cycle();
        check("waw_r9", dutRf[9], 32'h2);

        // Async reset with two buffered entries and three lost cycles counted.
        doReset();
        setWb(1, 20, 0, '0, 32'hD0);
        setMd(1, 4, 32'h14);
        cycle();
        setMd(1, 5, 32'h15);
        cycle();
        setMd(0, 0, '0);
        cycle();
        cycle();
        doReset();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("post_rst_we", rf_we, 1'b0);
            check("post_rst_ready", md_ready, 1'b1);
            cycle();
        end

        // Random traffic; the pipeline holds WB inputs whenever it is stalled.
        busy = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) busy = int'($urandom_range(30, 100));
            if (!stallExp)
                setWb(int'($urandom_range(1, 100)) <= busy, int'($urandom_range(0, 7)),
                      bit'($urandom_range(0, 1)), $urandom, $urandom);
            if (!(md_valid && !mdAccepted))
                setMd($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 999) == 0) doReset();
            else cycle();
        end
        setWb(0, 0, 0, '0, '0);
        setMd(0, 0, '0);
        repeat (6) cycle();

        for (int r = 0; r < 32; r++) check("rf_final", dutRf[r], modelRf[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the WB pipeline-register outputs (read data, ALU result, destination, RegWrite, MemToReg);
  - a multicycle unit (mult/div) that returns results asynchronously to the pipeline.
- WB has priority. Multicycle results are buffered in a small FIFO.
- A starvation counter freezes the pipeline for one cycle so buffered results cannot wait forever.
- Sits between the WB register and the register file; drives the pipeline stall line.

Parameters:
- DATA_W, 32, write-data width.
- ADDR_W, 5, register address width.
- FIFO_DEPTH, 2, multicycle result buffer entries; power of two, >=2.
- MAX_WAIT, 4, consecutive cycles a valid buffered head may lose arbitration before a forced stall; >=1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- wb_read_data  in  DATA_W  memory data from WB register.
- wb_alu_result  in  DATA_W  ALU result from WB register.
- wb_dest  in  ADDR_W  destination register from WB register.
- wb_reg_write  in  1  WB RegWrite.
- wb_mem_to_reg  in  1  WB MemToReg: 1 selects wb_read_data, 0 selects wb_alu_result.
- md_valid  in  1  multicycle result valid.
- md_dest  in  ADDR_W  multicycle destination register.
- md_data  in  DATA_W  multicycle result.
- md_ready  out  1  buffer can accept a result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- stall_pipe  out  1  freeze all pipeline registers for this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, all entry valid bits 0, starvation counter 0, stall_pipe 0, rf_we forced 0. md_ready=1 once rst_n=1.
- Write port outputs are combinational, same cycle.
- wb_active = wb_reg_write && wb_dest!=0 && !stall_pipe. Writes to register 0 never assert rf_we.
- Priority:
  - If wb_active: port gets WB.
  - Else if the FIFO head is valid: port gets the head, which is popped at the clock edge.
  - Otherwise rf_we=0.
- Invalid (killed) head entries are popped silently in any cycle and never use the port.
- Accept: push when md_valid && md_ready. md_ready = (count < FIFO_DEPTH), computed from registered count. A full FIFO does not accept even if it pops in the same cycle.
- md_dest=0 results are consumed (handshake completes) but not stored.
- Minimum latency from acceptance to write is 1 cycle.
- WAW ordering:
  - A WB write to X invalidates every buffered entry with dest X.
  - An md result accepted in the same cycle as a WB write to the same dest is dropped; md is treated as the older write.
- Starvation:
  - Counter increments each cycle a valid head exists and WB owns the port.
  - Counter clears on a head pop or when the FIFO empties.
  - When the counter reaches MAX_WAIT, stall_pipe is registered high for exactly one cycle and the counter clears.
- During stall_pipe=1:
  - The head owns the port.
  - The WB write is deferred. The frozen pipeline holds the WB inputs, so the write completes in the following cycle. Deferred WB does not kill the head, because head-then-WB is the correct order.
- Back-to-back: after a stall cycle, at least one non-stall cycle occurs before the next stall.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves count unchanged.
- Reset mid-operation discards buffered results. The multicycle unit is reset by the same rst_n.

Optional Feature:
- Macro: WB_ARB_STATS_EN
- Defined: adds output ports stat_stalls (16 bit) and stat_kills (16 bit).
  - stat_stalls counts stall_pipe cycles; stat_kills counts invalidated or dropped md results.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package regfile_arb_pkg:
  - constants DATA_W, ADDR_W, ZERO_REG=0;
  - typedef md_entry_t {valid, dest, data}.
- One sub-module, regfile_arb_fifo: the entry array, pointers, count, and parallel dest-compare kill logic. The top level holds the priority mux, starvation counter and stall register.

Test Plan:
- WB only: wb_reg_write=1, wb_dest=8, mem_to_reg=1, read_data=32'hCAFE0001 -> same cycle rf_we=1, rf_waddr=8, rf_wdata=32'hCAFE0001. The same with wb_dest=0 -> rf_we=0.
- MD into idle port: md_valid=1, md_dest=3, md_data=32'h55 with WB idle -> next cycle rf_we=1, waddr=3, wdata=32'h55; FIFO empty after.
- Full buffer: push 2 results while WB writes every cycle -> md_ready=0; a third md_valid is held off until a pop occurs.
- Starvation: 1 buffered entry, WB writes continuously, MAX_WAIT=4 -> stall_pipe=1 in exactly one cycle after 4 lost cycles; the head is written that cycle and the WB write lands in the next cycle.
- WAW kill: buffer dest=9 data=1, then WB writes dest 9 data=2 -> the entry is invalidated, never written, and r9 ends at 2. A same-cycle md dest=9 accept is dropped.
- Async reset asserted with 2 buffered entries and the counter at 3 -> immediately rf_we=0 and stall_pipe=0; after release md_ready=1 and no stale writes occur.
